// File: rtl/non_maximum_suppression.sv
// Canny non-maximum suppression over a raster stream: a 2W+3 line window slides across the frame,
// and each center pixel keeps its magnitude only if it is not below both neighbours along its gradient.
module non_maximum_suppression #(
    parameter int REDUCED_WIDTH  = 1035,
    parameter int REDUCED_HEIGHT = 226
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic       in_empty,
    input  logic [9:0] in_dout,
    output logic       out_wr_en,
    input  logic       out_full,
    output logic [7:0] out_din,
    output logic       frame_done
);

    localparam int W     = REDUCED_WIDTH;
    localparam int H     = REDUCED_HEIGHT;
    localparam int NPIX  = W * H;
    localparam int WIN   = 2 * W + 3;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int ROW_W = $clog2(H);
    localparam int COL_W = $clog2(W);

    typedef enum logic [1:0] {PROLOGUE, COMPUTE, OUTPUT} state_t;

    state_t             state_q, state_d;
    logic [9:0]         win_q [WIN];
    logic [7:0]         result_q, result_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic               flush;
    logic               last_pix;
    logic               border;
    logic               shift_en;
    logic [9:0]         shift_data;

    function automatic logic [7:0] nms(input logic [9:0] c,
                                       input logic [7:0] nw, input logic [7:0] n,
                                       input logic [7:0] ne, input logic [7:0] w,
                                       input logic [7:0] e,  input logic [7:0] sw,
                                       input logic [7:0] s,  input logic [7:0] se,
                                       input logic       on_border);
        logic [7:0] a;
        logic [7:0] b;
        case (c[9:8])
            2'd0:    begin a = w;  b = e;  end
            2'd1:    begin a = ne; b = sw; end
            2'd2:    begin a = n;  b = s;  end
            default: begin a = nw; b = se; end
        endcase
        if (!on_border && c[7:0] >= a && c[7:0] >= b)
            return c[7:0];
        return 8'd0;
    endfunction

    // Once every real pixel has been popped, the tail of the frame is pushed out with zero samples.
    assign flush      = (pop_cnt_q == CNT_W'(NPIX));
    assign last_pix   = (row_q == ROW_W'(H - 1)) && (col_q == COL_W'(W - 1));
    assign border     = (row_q == '0) || (row_q == ROW_W'(H - 1)) ||
                        (col_q == '0) || (col_q == COL_W'(W - 1));
    assign shift_data = (state_q == COMPUTE && flush) ? 10'h000 : in_dout;
    assign out_din    = reset ? 8'd0 : result_q;

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= PROLOGUE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PROLOGUE: if (!in_empty && pop_cnt_q == CNT_W'(W + 1)) state_d = COMPUTE;
            COMPUTE:  if (!in_empty || flush) state_d = OUTPUT;
            OUTPUT:   if (!out_full) state_d = last_pix ? PROLOGUE : COMPUTE;
            default:  state_d = PROLOGUE;
        endcase
    end

    always_comb begin
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        frame_done = 1'b0;
        shift_en   = 1'b0;
        if (!reset) begin
            case (state_q)
                PROLOGUE: begin
                    in_rd_en = ~in_empty;
                    shift_en = ~in_empty;
                end
                COMPUTE: begin
                    in_rd_en = ~in_empty & ~flush;
                    shift_en = ~in_empty | flush;
                end
                OUTPUT: begin
                    out_wr_en  = ~out_full;
                    frame_done = ~out_full & last_pix;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pop_cnt_d = pop_cnt_q + CNT_W'(in_rd_en);
        row_d     = row_q;
        col_d     = col_q;
        result_d  = result_q;
        if (state_q == COMPUTE && shift_en)
            result_d = nms(win_q[W + 1],
                           win_q[0][7:0],     win_q[1][7:0],     win_q[2][7:0],
                           win_q[W][7:0],     win_q[W + 2][7:0],
                           win_q[2 * W][7:0], win_q[2 * W + 1][7:0], win_q[2 * W + 2][7:0],
                           border);
        if (out_wr_en) begin
            if (col_q == COL_W'(W - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (frame_done) begin
            pop_cnt_d = '0;
            row_d     = '0;
            col_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pop_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            result_q  <= '0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            result_q  <= result_d;
        end
    end

    // Window starts every frame from zero so nothing leaks across frame boundaries.
    always_ff @(posedge clock) begin
        if (reset || frame_done) begin
            for (int i = 0; i < WIN; i++)
                win_q[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < WIN - 1; i++)
                win_q[i] <= win_q[i + 1];
            win_q[WIN - 1] <= shift_data;
        end
    end

endmodule

// File: tb/tb_non_maximum_suppression.sv
// Directed bench for non_maximum_suppression on an 8x4 frame with a behavioural FWFT source and sink.
module tb_non_maximum_suppression;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_rd_en;
    logic       in_empty;
    logic [9:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;
    logic       frame_done;

    non_maximum_suppression #(.REDUCED_WIDTH(8), .REDUCED_HEIGHT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [9:0] src   [64];
    logic [7:0] exp_v [32];
    logic [7:0] cap   [32];

    int wr_cnt, pops, done_cnt, done_at, pops_at_done, viol;
    int pop10_cyc, first_wr_cyc, stall_pops, stall_cycles;
    bit timed_out;

    task automatic load_blank();
        for (int i = 0; i < 32; i++) begin
            src[i]   = 10'h000;
            exp_v[i] = 8'd0;
        end
        for (int i = 32; i < 64; i++) src[i] = 10'h3C5;
    endtask

    task automatic set_px(input int r, input int c, input logic [1:0] dir, input logic [7:0] mag);
        src[r * 8 + c] = {dir, mag};
    endtask

    task automatic run_frame(input bit rand_empty, input bit do_stall, input int stop_after);
        int  idx;
        int  stall_left;
        bit  stall_done;
        bit  pop, wr, prev_wr;
        idx = 0; stall_left = 0; stall_done = 0; prev_wr = 0;
        wr_cnt = 0; pops = 0; done_cnt = 0; done_at = -1; pops_at_done = -1; viol = 0;
        pop10_cyc = -1; first_wr_cyc = -1; stall_pops = 0; stall_cycles = 0;
        for (int c = 0; c < 600 && wr_cnt < stop_after; c++) begin
            in_empty = rand_empty ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (do_stall && !stall_done && wr_cnt == 10) begin
                stall_left = 10;
                stall_done = 1;
            end
            out_full = (stall_left > 0);
            in_dout  = (idx < 64) ? src[idx] : 10'h000;
            @(negedge clock);
            pop = in_rd_en;
            wr  = out_wr_en;
            if (pop && in_empty) viol++;
            if (wr && prev_wr) viol++;
            if (frame_done && !wr) viol++;
            if (stall_left > 0) begin
                stall_cycles++;
                if (pop) stall_pops++;
                if (wr) viol++;
            end
            if (pop) begin
                pops++;
                if (pops == 10) pop10_cyc = c;
            end
            if (wr) begin
                if (wr_cnt == 0) first_wr_cyc = c;
                cap[wr_cnt] = out_din;
                if (frame_done) begin
                    done_cnt++;
                    done_at = wr_cnt;
                    pops_at_done = pops;
                end
                wr_cnt++;
            end
            prev_wr = wr;
            if (stall_left > 0) stall_left--;
            @(posedge clock);
            #1;
            if (pop) idx++;
        end
        timed_out = (wr_cnt < stop_after);
        in_empty = 1'b1;
        out_full = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_empty = 1'b0; out_full = 1'b0; in_dout = 10'h0FF;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", in_rd_en); end
        checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", out_wr_en); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (out_din !== 8'd0) begin errors++; $display("FAIL reset_out_din: got %0d expected 0", out_din); end
        @(posedge clock); #1;
        reset = 1'b0; in_empty = 1'b1;
        @(negedge clock);
        checks++; if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset: wr_en=%b rd_en=%b expected 0 0", out_wr_en, in_rd_en); end
        @(posedge clock); #1;
    endtask

    task automatic test_zero_frame();
        load_blank();
        run_frame(1'b0, 1'b0, 32);
        checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout: got %0d writes expected 32", wr_cnt); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL zero_pix%0d: got %0d expected %0d", i, cap[i], exp_v[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at !== 31) begin errors++; $display("FAIL zero_done_at: got %0d expected 31", done_at); end
        checks++; if (pops_at_done !== 32) begin errors++; $display("FAIL zero_pops: got %0d expected 32", pops_at_done); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL zero_protocol: got %0d violations expected 0", viol); end
        checks++; if (first_wr_cyc !== pop10_cyc + 2) begin errors++; $display("FAIL zero_latency: first write cycle %0d expected %0d", first_wr_cyc, pop10_cyc + 2); end
    endtask

    task automatic test_isolated_max();
        load_blank();
        set_px(1, 3, 2'd0, 8'd100);
        set_px(1, 2, 2'd0, 8'd50);
        set_px(1, 4, 2'd0, 8'd50);
        exp_v[11] = 8'd100;
        run_frame(1'b0, 1'b0, 32);
        checks++; if (timed_out) begin errors++; $display("FAIL iso_timeout: got %0d writes expected 32", wr_cnt); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL iso_pix%0d: got %0d expected %0d", i, cap[i], exp_v[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL iso_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_pair_suppress();
        load_blank();
        set_px(2, 4, 2'd0, 8'd60);
        set_px(2, 5, 2'd0, 8'd80);
        exp_v[21] = 8'd80;
        run_frame(1'b0, 1'b0, 32);
        checks++; if (timed_out) begin errors++; $display("FAIL pair_timeout: got %0d writes expected 32", wr_cnt); end
        checks++; if (cap[20] !== 8'd0) begin errors++; $display("FAIL pair_pix20: got %0d expected 0", cap[20]); end
        checks++; if (cap[21] !== 8'd80) begin errors++; $display("FAIL pair_pix21: got %0d expected 80", cap[21]); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL pair_pix%0d: got %0d expected %0d", i, cap[i], exp_v[i]); end
        end
    endtask

    task automatic test_border();
        load_blank();
        set_px(0, 2, 2'd0, 8'd200);
        run_frame(1'b0, 1'b0, 32);
        checks++; if (timed_out) begin errors++; $display("FAIL border_timeout: got %0d writes expected 32", wr_cnt); end
        checks++; if (cap[2] !== 8'd0) begin errors++; $display("FAIL border_pix2: got %0d expected 0", cap[2]); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL border_pix%0d: got %0d expected %0d", i, cap[i], exp_v[i]); end
        end
    endtask

    task automatic test_stall_directions();
        load_blank();
        set_px(1, 2, 2'd2, 8'd90);
        set_px(2, 2, 2'd0, 8'd90);
        set_px(1, 5, 2'd1, 8'd40);
        set_px(2, 4, 2'd3, 8'd50);
        set_px(2, 6, 2'd3, 8'd30);
        exp_v[10] = 8'd90;
        exp_v[18] = 8'd90;
        exp_v[20] = 8'd50;
        run_frame(1'b1, 1'b1, 32);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got %0d writes expected 32", wr_cnt); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL stall_pix%0d: got %0d expected %0d", i, cap[i], exp_v[i]); end
        end
        checks++; if (stall_cycles !== 10) begin errors++; $display("FAIL stall_window: got %0d cycles expected 10", stall_cycles); end
        checks++; if (stall_pops > 1) begin errors++; $display("FAIL stall_pops: got %0d pops expected at most 1", stall_pops); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL stall_protocol: got %0d violations expected 0", viol); end
        checks++; if (done_cnt !== 1 || done_at !== 31) begin errors++; $display("FAIL stall_done: got count %0d at %0d expected 1 at 31", done_cnt, done_at); end
        checks++; if (pops_at_done !== 32) begin errors++; $display("FAIL stall_pops_total: got %0d expected 32", pops_at_done); end
    endtask

    task automatic test_reset_midframe();
        load_blank();
        for (int i = 0; i < 32; i++) src[i] = {2'(i % 4), 8'(i * 7 + 3)};
        run_frame(1'b0, 1'b0, 15);
        checks++; if (wr_cnt !== 15) begin errors++; $display("FAIL mid_partial: got %0d writes expected 15", wr_cnt); end
        reset = 1'b1; in_empty = 1'b0; out_full = 1'b0;
        @(negedge clock);
        checks++; if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0 || out_din !== 8'd0) begin errors++; $display("FAIL mid_reset_outputs: rd=%b wr=%b din=%0d expected 0 0 0", in_rd_en, out_wr_en, out_din); end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0; in_empty = 1'b1;
        load_blank();
        set_px(1, 3, 2'd0, 8'd100);
        set_px(1, 2, 2'd0, 8'd50);
        set_px(1, 4, 2'd0, 8'd50);
        exp_v[11] = 8'd100;
        run_frame(1'b0, 1'b0, 32);
        checks++; if (timed_out) begin errors++; $display("FAIL mid_timeout: got %0d writes expected 32", wr_cnt); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL mid_pix%0d: got %0d expected %0d", i, cap[i], exp_v[i]); end
        end
        checks++; if (done_cnt !== 1 || done_at !== 31) begin errors++; $display("FAIL mid_done: got count %0d at %0d expected 1 at 31", done_cnt, done_at); end
    endtask

    initial begin
        reset = 1'b1; in_empty = 1'b1; out_full = 1'b0; in_dout = 10'h000;
        test_reset();
        test_zero_frame();
        test_isolated_max();
        test_pair_suppress();
        test_border();
        test_stall_directions();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
